// File: rtl/reg_share_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the shared register.
// master: requester/register side; slave: arbiter side.
interface reg_share_arbiter_if #(
    parameter int unsigned WIDTH = 10
);
    logic             req0;
    logic             we0;
    logic [WIDTH-1:0] din0;
    logic             req1;
    logic             we1;
    logic [WIDTH-1:0] din1;
    logic             gnt0;
    logic             gnt1;
    logic             ld;
    logic [WIDTH-1:0] reg_d;
    logic [WIDTH-1:0] reg_q;
    logic [WIDTH-1:0] dout;
    logic             busy;

    modport master (
        output req0, we0, din0, req1, we1, din1, reg_q,
        input  gnt0, gnt1, ld, reg_d, dout, busy
    );

    modport slave (
        input  req0, we0, din0, req1, we1, din1, reg_q,
        output gnt0, gnt1, ld, reg_d, dout, busy
    );
endinterface

// File: rtl/reg_share_arbiter.sv
// Two-requester round-robin arbiter guarding one shared register.
// A grant lasts while its owner requests; if the other side is waiting, the
// owner is forced off after HOLD_MAX cycles. Every release is followed by a
// one-cycle GAP (bus turnaround) and an IDLE cycle where arbitration happens.
module reg_share_arbiter #(
    parameter int unsigned WIDTH    = 10,
    parameter int unsigned HOLD_MAX = 8
) (
    input logic               clk,
    input logic               rst,
    reg_share_arbiter_if.slave bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT0 = 2'd1;
    localparam logic [1:0] GRANT1 = 2'd2;
    localparam logic [1:0] GAP    = 2'd3;

    // HOLD_MAX is at most 255, so the tenure counter fits in 8 bits.
    localparam logic [7:0] CNT_MAX = 8'(HOLD_MAX - 1);

    logic [1:0] state;
    logic [1:0] state_nx;
    logic       ptr;
    logic       ptr_nx;
    logic [7:0] cnt;
    logic [7:0] cnt_nx;
    logic       gnt0_r;
    logic       gnt1_r;
    logic       busy_r;
    logic       in_g0;
    logic       in_g1;
    logic       hold_done;

    assign in_g0     = (state == GRANT0);
    assign in_g1     = (state == GRANT1);
    assign hold_done = (cnt == CNT_MAX);

    // Next-state: arbitrate in IDLE, release on drop or forced release.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
                    state_nx = ptr ? GRANT1 : GRANT0;
                end else if (bus.req0) begin
                    state_nx = GRANT0;
                end else if (bus.req1) begin
                    state_nx = GRANT1;
                end
            end
            GRANT0: begin
                if (!bus.req0 || (bus.req1 && hold_done)) begin
                    state_nx = GAP;
                end
            end
            GRANT1: begin
                if (!bus.req1 || (bus.req0 && hold_done)) begin
                    state_nx = GAP;
                end
            end
            GAP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Pointer flips to the other requester whenever a grant is entered.
    always_comb begin
        ptr_nx = ptr;
        if (state == IDLE && state_nx == GRANT0) begin
            ptr_nx = 1'b1;
        end else if (state == IDLE && state_nx == GRANT1) begin
            ptr_nx = 1'b0;
        end
    end

    // Tenure counter: zero on entry, counts each held cycle, saturates.
    always_comb begin
        cnt_nx = '0;
        if ((in_g0 || in_g1) && state_nx == state) begin
            cnt_nx = hold_done ? cnt : cnt + 8'd1;
        end
    end

    // State, pointer, counter and registered grant/busy flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= 1'b0;
            cnt    <= '0;
            gnt0_r <= 1'b0;
            gnt1_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            state  <= state_nx;
            ptr    <= ptr_nx;
            cnt    <= cnt_nx;
            gnt0_r <= (state_nx == GRANT0);
            gnt1_r <= (state_nx == GRANT1);
            busy_r <= (state_nx != IDLE);
        end
    end

    // Datapath: only the current owner can load or see the register.
    always_comb begin
        bus.ld    = (in_g0 && bus.req0 && bus.we0) || (in_g1 && bus.req1 && bus.we1);
        bus.reg_d = '0;
        if (in_g0) begin
            bus.reg_d = bus.din0;
        end else if (in_g1) begin
            bus.reg_d = bus.din1;
        end
        bus.dout = (gnt0_r || gnt1_r) ? bus.reg_q : '0;
        bus.gnt0 = gnt0_r;
        bus.gnt1 = gnt1_r;
        bus.busy = busy_r;
    end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Scoreboard bench for reg_share_arbiter: the driver applies one cycle of
// stimulus, predicts the DUT response with an ownership/tenure model and
// queues it; the monitor pops and compares on every falling edge.
module tb_reg_share_arbiter;

    localparam int unsigned W  = 10;
    localparam int unsigned HM = 8;

    typedef struct {
        logic         g0;
        logic         g1;
        logic         busy;
        logic         ld;
        logic [W-1:0] regd;
        logic [W-1:0] dout;
        logic [W-1:0] regv;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [W-1:0] shared_reg = '0;
    bit stim_done = 1'b0;
    int checks   = 0;
    int failures = 0;
    exp_t sbq[$];

    // Model state: owner (-1 none), cycles held so far, turnaround, tie winner.
    int owner  = -1;
    int tenure = 0;
    bit turn   = 1'b0;
    int pref   = 0;
    logic [W-1:0] mreg = '0;

    reg_share_arbiter_if #(.WIDTH(W)) bus ();

    reg_share_arbiter #(
        .WIDTH   (W),
        .HOLD_MAX(HM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // External shared register loaded by the arbiter.
    always @(posedge clk) if (bus.ld) shared_reg <= bus.reg_d;
    assign bus.reg_q = shared_reg;

    task automatic drive(input bit r0, input bit w0, input logic [W-1:0] d0,
                         input bit r1, input bit w1, input logic [W-1:0] d1,
                         input bit rv);
        exp_t e;
        bit rq[2];
        bit wq[2];
        logic [W-1:0] dq[2];
        int oth;
        @(posedge clk);
        #2;
        rst = rv;
        bus.req0 = r0; bus.we0 = w0; bus.din0 = d0;
        bus.req1 = r1; bus.we1 = w1; bus.din1 = d1;
        rq[0] = r0; wq[0] = w0; dq[0] = d0;
        rq[1] = r1; wq[1] = w1; dq[1] = d1;
        e.regv = mreg;
        if (rv) begin
            e.g0 = 0; e.g1 = 0; e.busy = 0; e.ld = 0; e.regd = '0; e.dout = '0;
            owner = -1; tenure = 0; turn = 0; pref = 0;
        end else begin
            e.g0   = (owner == 0);
            e.g1   = (owner == 1);
            e.busy = (owner >= 0) || turn;
            e.ld   = (owner >= 0) && rq[owner] && wq[owner];
            e.regd = (owner >= 0) ? dq[owner] : '0;
            e.dout = (owner >= 0) ? mreg : '0;
            if (e.ld) mreg = e.regd;
            if (owner >= 0) begin
                oth = 1 - owner;
                if (!rq[owner] || (rq[oth] && tenure >= int'(HM) - 1)) begin
                    owner = -1;
                    turn  = 1'b1;
                end else begin
                    tenure++;
                end
            end else if (turn) begin
                turn = 1'b0;
            end else if (rq[0] || rq[1]) begin
                owner  = (rq[0] && rq[1]) ? pref : (rq[0] ? 0 : 1);
                tenure = 0;
                pref   = (owner == 0) ? 1 : 0;
            end
        end
        sbq.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: compare queued predictions against the DUT each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("gnt0", 32'(bus.gnt0), 32'(e.g0));
                chk("gnt1", 32'(bus.gnt1), 32'(e.g1));
                chk("gnt_excl", 32'(bus.gnt0 & bus.gnt1), 32'd0);
                chk("busy", 32'(bus.busy), 32'(e.busy));
                chk("ld", 32'(bus.ld), 32'(e.ld));
                chk("reg_d", 32'(bus.reg_d), 32'(e.regd));
                chk("dout", 32'(bus.dout), 32'(e.dout));
                chk("shared_reg", 32'(shared_reg), 32'(e.regv));
            end
            if (stim_done && sbq.size() == 0) begin
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    // Stimulus: directed scenarios, then randomized traffic with rare resets.
    initial begin
        bit r0, r1, rv;
        bus.req0 = 0; bus.we0 = 0; bus.din0 = '0;
        bus.req1 = 0; bus.we1 = 0; bus.din1 = '0;
        repeat (3) drive(0, 0, '0, 0, 0, '0, 1);
        // Tie after reset, then continuous contention for round-robin.
        repeat (42) drive(1, 0, '0, 1, 0, '0, 0);
        repeat (3) drive(0, 0, '0, 0, 0, '0, 0);
        // Single write by requester 0, then read-back.
        drive(1, 0, '0, 0, 0, '0, 0);
        drive(1, 0, '0, 0, 0, '0, 0);
        drive(1, 1, 10'h2A5, 0, 0, '0, 0);
        repeat (2) drive(1, 0, '0, 0, 0, '0, 0);
        // Non-owner write attempt leading into a forced release.
        repeat (5) drive(1, 1, 10'h155, 1, 1, 10'h3FF, 0);
        drive(0, 0, '0, 1, 1, 10'h0AB, 0);
        repeat (3) drive(0, 0, '0, 1, 1, 10'h1C3, 0);
        // Asynchronous reset in the middle of a requester 1 write tenure.
        repeat (2) drive(0, 0, '0, 1, 1, 10'h3FF, 1);
        repeat (4) drive(0, 0, '0, 1, 1, 10'h066, 0);
        repeat (3) drive(0, 0, '0, 0, 0, '0, 0);
        r0 = 0;
        r1 = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) r0 = ~r0;
            if ($urandom_range(0, 7) == 0) r1 = ~r1;
            rv = ($urandom_range(0, 299) == 0);
            drive(r0, 1'($urandom), W'($urandom), r1, 1'($urandom), W'($urandom), rv);
        end
        stim_done = 1'b1;
    end

endmodule
